csa_pipe_adder: RTL and testbench
=================================

# csa_pipe_adder

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshaking on both sides. The block generalises the team's fixed 4-bit carry-select adder to WIDTH bits, split into BLOCK-bit carry-select segments. It registers one segment per pipeline stage and adds a subtract mode, signed-overflow reporting and full backpressure. It sits between an operand source and a result consumer in the Tiny Tapeout user project, behind the tt_um top wrapper.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of BLOCK, ≥ BLOCK.
- BLOCK, 4: carry-select segment width; also the number of bits resolved per pipeline stage.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; ignored when sub=1.
- sub  in  1  1 = compute a − b.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- NSTG = WIDTH/BLOCK stages; stage k (k = 0..NSTG−1) owns segment bits [k·BLOCK +: BLOCK].
- Each segment computes two sums, for carry-in 0 and carry-in 1. The real carry, registered from stage k−1 (c0 for stage 0), selects one of them.
- The selected segment sum and segment carry are registered into stage k.
- Operand bits of segments not yet resolved travel with the beat; resolved sum bits travel forward.
- ovf = carry into MSB XOR carry out of MSB, evaluated in the last stage.
- Per-stage valid bit v[k]. Stage k advances when v[k] && (!v[k+1] || adv[k+1]). The last stage advances on out_ready.
- in_ready = !v[0] || adv[0]. This is combinational; in_ready never depends on in_valid.
- A beat is accepted on in_valid && in_ready. Beats are never dropped, duplicated or reordered.
- out_valid = v[NSTG−1]. While out_valid=1 and out_ready=0, sum/cout/ovf are held stable.

## Timing
- Reset, asynchronous: all v[k]=0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once rst_n is released.
- Latency: a beat accepted at edge t appears at out_valid at edge t+NSTG−1, i.e. NSTG cycles counting the acceptance edge. Default value: 4.
- Throughput: 1 beat/cycle while out_ready=1.
- Full pipeline (all v=1) with out_ready=0: in_ready=0.
- Full pipeline with out_ready=1: accept and emit in the same cycle; no bubble.
- Bubbles collapse: a stall fills empty stages upstream of the stall point.
- Reset asserted mid-operation: all in-flight beats are discarded immediately and outputs return to reset values.
- Carry wrap: an all-ones plus one result wraps to 0 with cout=1.

## Configuration
- CSA_SAT_EN defined: when ovf=1, sum is clamped to the signed extreme in the direction of the true result. That is 0x7FFF for positive overflow and 0x8000 for negative overflow at WIDTH=16. ovf and cout are unchanged.
- CSA_SAT_EN not defined: sum wraps modulo 2^WIDTH. ovf is still reported.

## Structure
- Package csa_pkg holds:
  - function nstg(WIDTH, BLOCK);
  - the stage payload struct (valid, carry, resolved sum bits, pending a/b bits);
  - a localparam for the default latency.
- Sub-module csa_seg: combinational BLOCK-bit carry-select segment. Inputs a, b, cin. Outputs sum, cout, and the MSB carry-in needed for ovf. It is instantiated once per stage by a generate loop.

## Test plan
All scenarios use WIDTH=16, BLOCK=4.
- Single add: a=0x1234, b=0x0FFF, cin=0, out_ready=1 → after 4 cycles sum=0x2233, cout=0, ovf=0, out_valid high for exactly 1 cycle.
- Carry wrap: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
- Subtract: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
- Overflow: a=0x7FFF, b=0x0001 → ovf=1, with sum=0x8000 (macro off) or sum=0x7FFF (CSA_SAT_EN on). Also a=0x8000, b=0xFFFF → ovf=1, with sum=0x7FFF (off) or 0x8000 (on).
- Backpressure: 8 back-to-back beats a=i, b=i (i=1..8), out_ready=0 for cycles 3–8 → in_ready falls after 4 beats are in flight. On release, results 2,4,…,16 emerge in order, none lost, sum stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 and sum=0 immediately. After release, in_ready=1 and no stale beat ever appears.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and helpers for the pipelined carry-select adder/subtractor.
// The stage payload is sized for the widest supported operand; unused high bits stay zero.
package csa_pkg;

  localparam int CSA_MAX_W = 64;

  function automatic int nstg(input int width, input int block);
    return width / block;
  endfunction

  // Default build is WIDTH=16, BLOCK=4: one cycle per resolved segment.
  localparam int CSA_LATENCY = nstg(16, 4);

  typedef struct packed {
    logic                 valid;
    logic                 carry;   // carry out of the most recently resolved segment
    logic                 msb_c;   // carry into that segment's top bit, used for ovf
    logic [CSA_MAX_W-1:0] sum;     // resolved sum bits (low segments)
    logic [CSA_MAX_W-1:0] a;       // pending operand A bits
    logic [CSA_MAX_W-1:0] b;       // pending effective operand B bits
  } csa_stage_t;

endpackage

// File: rtl/csa_seg.sv
// Combinational BLOCK-bit carry-select segment: both carry-in sums are formed in
// parallel and the real carry picks one.
module csa_seg #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [BLOCK:0] sum0;
  logic [BLOCK:0] sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign {cout, sum} = cin ? sum1 : sum0;

  // Carry into the top bit recovered from its sum bit.
  assign msb_cin = a[BLOCK-1] ^ b[BLOCK-1] ^ sum[BLOCK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor, one BLOCK-bit segment per stage, valid/ready both sides.
// Define CSA_SAT_EN to clamp the sum to the signed extreme when ovf is set.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = nstg(WIDTH, BLOCK);

  if (WIDTH % BLOCK != 0 || WIDTH < BLOCK || WIDTH > CSA_MAX_W) begin : g_cfg_err
    $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK, >= BLOCK and <= CSA_MAX_W");
  end

  csa_stage_t       in_beat;
  csa_stage_t       st  [NSTG];
  csa_stage_t       src [NSTG];
  logic [NSTG-1:0]  v;
  logic [NSTG-1:0]  load;
  logic             ready_up;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    in_beat              = '0;
    in_beat.valid        = in_valid;
    in_beat.carry        = sub | cin;
    in_beat.a[WIDTH-1:0] = a;
    in_beat.b[WIDTH-1:0] = sub ? ~b : b;
  end

  // A stage may load when it is empty or its occupant moves on; walk from the output back.
  always_comb begin
    load     = '0;
    ready_up = out_ready;
    for (int k = NSTG - 1; k >= 0; k--) begin
      load[k]  = ~v[k] | ready_up;
      ready_up = load[k];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    csa_stage_t       nxt;
    logic [BLOCK-1:0] seg_sum;
    logic             seg_cout;
    logic             seg_msb_c;

    if (k == 0) begin : g_head
      assign src[k] = in_beat;
    end else begin : g_body
      assign src[k] = st[k-1];
    end

    csa_seg #(.BLOCK(BLOCK)) u_seg (
      .a       (src[k].a[k*BLOCK +: BLOCK]),
      .b       (src[k].b[k*BLOCK +: BLOCK]),
      .cin     (src[k].carry),
      .sum     (seg_sum),
      .cout    (seg_cout),
      .msb_cin (seg_msb_c)
    );

    always_comb begin
      nxt                        = src[k];
      nxt.sum[k*BLOCK +: BLOCK]  = seg_sum;
      nxt.carry                  = seg_cout;
      nxt.msb_c                  = seg_msb_c;
    end

    // NOTE: payload registers are reset too, because sum/cout/ovf must read 0 straight out of reset.
    // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st[k] <= '0;
      end else if (load[k]) begin
        if (src[k].valid) st[k] <= nxt;
        else              st[k].valid <= 1'b0;
      end
    end

    assign v[k] = st[k].valid;
  end

  csa_stage_t last;
  logic       unused_last;

  assign last        = st[NSTG-1];
  assign unused_last = ^{last.a, last.b, last.sum};

  assign out_valid = last.valid;
  assign cout      = last.carry;
  assign ovf       = last.msb_c ^ last.carry;

`ifdef CSA_SAT_EN
  // Overflow direction follows cout: positive overflow leaves cout=0, negative leaves cout=1.
  assign sum = ovf ? {cout, {(WIDTH-1){~cout}}} : last.sum[WIDTH-1:0];
`else
  assign sum = last.sum[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed self-checking bench for csa_pipe_adder at WIDTH=16, BLOCK=4.
// Expected values are hand-computed; CSA_SAT_EN selects the clamped overflow results.
module tb_csa_pipe_adder;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int LAT   = 4;

`ifdef CSA_SAT_EN
  localparam logic [15:0] POS_OVF_SUM = 16'h7FFF;
  localparam logic [15:0] NEG_OVF_SUM = 16'h8000;
`else
  localparam logic [15:0] POS_OVF_SUM = 16'h8000;
  localparam logic [15:0] NEG_OVF_SUM = 16'h7FFF;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             cin       = 1'b0;
  logic             sub       = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_cmp = 0;
  int n_mis = 0;

  csa_pipe_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat with out_ready=1: checks latency, result and a one-cycle out_valid pulse.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic tsub, input logic [15:0] esum,
                        input logic ecout, input logic eovf);
    int k;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, LAT);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
    check({tag, "_ovf"}, ovf, eovf);
    @(negedge clk);
    check({tag, "_one_shot"}, out_valid, 0);
  endtask

  initial begin
    int i;
    int n_out;
    int stale;

    // Reset state, while held and right after release.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // Directed arithmetic.
    run_op("add",      16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("add_cin",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, POS_OVF_SUM, 1'b0, 1'b1);
    run_op("ovf_neg",  16'h8000, 16'hFFFF, 1'b0, 1'b0, NEG_OVF_SUM, 1'b1, 1'b1);

    // Backpressure: 8 beats a=b=i, consumer stalled for the first 8 cycles.
    i = 1;
    n_out = 0;
    cin = 1'b0;
    sub = 1'b0;
    for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      in_valid  = (i <= 8);
      a = 16'(i);
      b = 16'(i);
      #1;
      if (cyc == 4) begin
        check("bp_full_in_ready", in_ready, 0);
        check("bp_full_accepted", i, 5);
        check("bp_full_out_valid", out_valid, 1);
      end
      if (cyc == 8) check("bp_release_in_ready", in_ready, 1);
      if (cyc >= 4 && !out_ready) check("bp_stall_sum", sum, 16'h0002);
      if (out_ready) check("bp_no_bubble", out_valid, 1);
      if (out_valid && out_ready) begin
        check("bp_order_sum", sum, 2 * (n_out + 1));
        n_out++;
      end
      if (in_valid && in_ready) i++;
    end
    check("bp_count", n_out, 8);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("bp_drained", out_valid, 0);

    // Reset with 3 beats in flight, oldest already presented at the output.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_sum", sum, 16'h2222);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("mid_in_ready", in_ready, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_no_stale", stale, 0);
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
